// File: rtl/md5_padder.sv
// md5_padder
//   Turns a byte stream into MD5-padded 512-bit blocks and hands each block
//   to an external MD5 compression core. The padding is 0x80, then zeros, then
//   the 64-bit message bit length in little-endian order in bytes 56..63 of
//   the final block. Extra blocks are added when the 0x80 marker or the length
//   does not fit in the current block.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     byte-stream valid
//   in_ready     padder can accept a byte (IDLE and LOAD only)
//   in_data      message byte
//   in_last      final beat of the message
//   in_empty     with in_last: the beat carries no byte
//   block_data   512-bit block to the core, byte i at bits [8i +: 8]
//   core_start   one-cycle pulse for the first block of a message
//   core_resume  one-cycle pulse for each later block
//   core_done    core finished flag (level)
//   msg_done     one-cycle pulse once the final block has been hashed
//   busy         message in progress
module md5_padder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_empty,
    output logic [0:511] block_data,
    output logic         core_start,
    output logic         core_resume,
    input  logic         core_done,
    output logic         msg_done,
    output logic         busy
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] PAD   = 3'd2;
    localparam logic [2:0] LEN   = 3'd3;
    localparam logic [2:0] ISSUE = 3'd4;
    localparam logic [2:0] WAIT  = 3'd5;

    // What to do once the core reports the current block as hashed.
    localparam logic [1:0] NXT_LOAD = 2'd0;
    localparam logic [1:0] NXT_PAD  = 2'd1;
    localparam logic [1:0] NXT_LEN  = 2'd2;
    localparam logic [1:0] NXT_DONE = 2'd3;

    logic [2:0]  state;
    logic [5:0]  ptr;
    logic [63:0] bit_cnt;
    logic [1:0]  after_wait;
    logic        first_blk;
    logic        exact;
    logic        fire;

    assign in_ready    = (state == IDLE) || (state == LOAD);
    assign fire        = in_valid && in_ready;
    assign busy        = (state != IDLE);
    assign core_start  = (state == ISSUE) && first_blk;
    assign core_resume = (state == ISSUE) && !first_blk;

    // Main sequencer.
    // 'exact' marks a message whose last byte filled byte 63: that block is
    // issued untouched and the 0x80 marker opens the following block. It is
    // derived from the final data byte itself rather than from ptr==0 in PAD,
    // so an empty tail beat arriving after a full block is padded normally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 6'd0;
            bit_cnt    <= 64'd0;
            after_wait <= NXT_LOAD;
            first_blk  <= 1'b0;
            exact      <= 1'b0;
            msg_done   <= 1'b0;
            block_data <= '0;
        end else begin
            msg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        first_blk  <= 1'b1;
                        exact      <= 1'b0;
                        after_wait <= NXT_LOAD;
                        if (in_last && in_empty) begin
                            ptr     <= 6'd0;
                            bit_cnt <= 64'd0;
                            state   <= PAD;
                        end else begin
                            block_data[0 +: 8] <= in_data;
                            ptr                <= 6'd1;
                            bit_cnt            <= 64'd8;
                            state              <= in_last ? PAD : LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (fire) begin
                        if (in_last && in_empty) begin
                            state <= PAD;
                        end else begin
                            block_data[{ptr, 3'b000} +: 8] <= in_data;
                            ptr     <= ptr + 6'd1;
                            bit_cnt <= bit_cnt + 64'd8;
                            if (in_last) begin
                                exact <= (ptr == 6'd63);
                                state <= PAD;
                            end else if (ptr == 6'd63) begin
                                after_wait <= NXT_LOAD;
                                state      <= ISSUE;
                            end
                        end
                    end
                end

                PAD: begin
                    if (exact) begin
                        exact      <= 1'b0;
                        after_wait <= NXT_PAD;
                        state      <= ISSUE;
                    end else begin
                        for (int i = 0; i < 64; i++) begin
                            if (i == int'(ptr)) begin
                                block_data[i*8 +: 8] <= 8'h80;
                            end else if (i > int'(ptr)) begin
                                block_data[i*8 +: 8] <= 8'h00;
                            end
                        end
                        // Length fits only if the marker left bytes 56..63 free.
                        if (ptr <= 6'd55) begin
                            state <= LEN;
                        end else begin
                            after_wait <= NXT_LEN;
                            state      <= ISSUE;
                        end
                    end
                end

                LEN: begin
                    for (int k = 0; k < 8; k++) begin
                        block_data[(56+k)*8 +: 8] <= bit_cnt[k*8 +: 8];
                    end
                    after_wait <= NXT_DONE;
                    state      <= ISSUE;
                end

                ISSUE: begin
                    // core_done is deliberately not looked at here: it may
                    // still be high from the previous block.
                    first_blk <= 1'b0;
                    state     <= WAIT;
                end

                WAIT: begin
                    if (core_done) begin
                        case (after_wait)
                            NXT_LOAD: begin
                                block_data <= '0;
                                state      <= LOAD;
                            end
                            NXT_PAD: begin
                                block_data <= '0;
                                state      <= PAD;
                            end
                            NXT_LEN: begin
                                block_data <= '0;
                                state      <= LEN;
                            end
                            default: begin
                                ptr      <= 6'd0;
                                msg_done <= 1'b1;
                                state    <= IDLE;
                            end
                        endcase
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_padder.sv
// tb_md5_padder
//   Self-checking bench for md5_padder. A reference model builds the
//   expected padded blocks of each message straight from the MD5 padding rule
//   (message, 0x80, zeros to 56 mod 64, 64-bit little-endian bit length) and
//   queues them; a compare process checks every issued block, the start /
//   resume choice, block stability while the core works, in_ready / busy
//   during hashing and the msg_done pulse. A small core model answers each
//   issue with core_done after a random delay, leaving a stale high level
//   during the issue cycle. Directed messages add hand-computed byte checks.
module tb_md5_padder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_empty;
    logic [0:511] block_data;
    logic         core_start;
    logic         core_resume;
    logic         core_done;
    logic         msg_done;
    logic         busy;

    typedef struct {
        logic [0:511] data;
        bit           first;
        bit           last;
    } blk_t;

    int           tests = 0;
    int           fails = 0;
    blk_t         expq[$];
    logic [0:511] issued[$];
    logic [7:0]   msgq[$];
    bit           inflight = 1'b0;
    bit           held_last = 1'b0;
    bit           pend_md = 1'b0;
    logic [0:511] held;
    int           md_count = 0;

    always #5 clk = ~clk;

    md5_padder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_empty    (in_empty),
        .block_data  (block_data),
        .core_start  (core_start),
        .core_resume (core_resume),
        .core_done   (core_done),
        .msg_done    (msg_done),
        .busy        (busy)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkBlockOutput(input string name, input logic [0:511] act, input logic [0:511] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte n of an already issued block, for hand-computed checks.
    function automatic logic [7:0] issuedByte(input int blk, input int n);
        logic [0:511] b;
        b = issued[blk];
        return b[n*8 +: 8];
    endfunction

    // Reference model: standard MD5 padding of msgq, split into 64-byte blocks.
    task automatic buildExpected();
        int          len;
        int          nblk;
        int          total;
        int          idx;
        logic [63:0] bits;
        logic [7:0]  v;
        blk_t        e;
        len   = msgq.size();
        nblk  = (len + 8) / 64 + 1;
        total = nblk * 64;
        bits  = 64'(len) * 64'd8;
        for (int b = 0; b < nblk; b++) begin
            for (int j = 0; j < 64; j++) begin
                idx = b * 64 + j;
                if (idx < len)              v = msgq[idx];
                else if (idx == len)        v = 8'h80;
                else if (idx >= total - 8)  v = bits[8*(idx-(total-8)) +: 8];
                else                        v = 8'h00;
                e.data[j*8 +: 8] = v;
            end
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            expq.push_back(e);
        end
    endtask

    task automatic sendBeat(input logic [7:0] d, input bit last, input bit empty);
        int tries;
        bit rdy;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_empty = empty;
        tries    = 0;
        forever begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            tries++;
            if (tries > 2000) begin
                checkOutput("beat_accept_timeout", 64'(tries), 64'd0);
                break;
            end
            @(negedge clk);
        end
    endtask

    // Sends msgq as one message; optionally with idle gaps and an empty tail.
    task automatic applyStimulus(input bit gaps);
        int n;
        bit empty_tail;
        buildExpected();
        n = msgq.size();
        empty_tail = gaps && (n > 0) && ($urandom_range(0, 3) == 0);
        if (n == 0) begin
            sendBeat(8'h00, 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
                sendBeat(msgq[i], (i == n - 1) && !empty_tail, 1'b0);
            end
            if (empty_tail) sendBeat(8'($urandom), 1'b1, 1'b1);
        end
    endtask

    task automatic waitIdle();
        bit reached;
        @(negedge clk);
        in_valid = 1'b0;
        reached  = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (expq.size() == 0 && !inflight && !busy) begin
                reached = 1'b1;
                break;
            end
        end
        checkOutput("reach_idle", 64'(reached), 64'd1);
    endtask

    // Core model: keeps core_done high between jobs, drops it the cycle after
    // an issue and raises it again after a random delay.
    initial begin
        int d;
        core_done = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (core_start || core_resume) begin
                @(posedge clk);
                #2 core_done = 1'b0;
                d = $urandom_range(0, 4);
                repeat (d) @(posedge clk);
                #2 core_done = 1'b1;
            end
        end
    end

    // Compare process.
    initial begin
        blk_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                inflight = 1'b0;
                pend_md  = 1'b0;
                continue;
            end
            checkOutput("msg_done", 64'(msg_done), 64'(pend_md));
            if (msg_done) md_count++;
            pend_md = 1'b0;
            if (core_start || core_resume) begin
                checkOutput("issue_while_busy", 64'(inflight), 64'd0);
                checkOutput("ready_in_issue", 64'(in_ready), 64'd0);
                if (expq.size() == 0) begin
                    checkOutput("unexpected_issue", 64'(core_start | core_resume), 64'd0);
                    held_last = 1'b0;
                end else begin
                    e = expq.pop_front();
                    checkBlockOutput("block", block_data, e.data);
                    checkOutput("core_start", 64'(core_start), 64'(e.first));
                    checkOutput("core_resume", 64'(core_resume), 64'(!e.first));
                    held_last = e.last;
                end
                held     = block_data;
                inflight = 1'b1;
                issued.push_back(block_data);
            end else if (inflight) begin
                checkBlockOutput("block_stable", block_data, held);
                checkOutput("ready_in_wait", 64'(in_ready), 64'd0);
                checkOutput("busy_in_wait", 64'(busy), 64'd1);
                if (core_done) begin
                    inflight = 1'b0;
                    pend_md  = held_last;
                end
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        checkOutput("watchdog", 64'd1, 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int md_before;
        int n;
        bit seen;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        in_empty = 1'b0;

        // Reset values.
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_core_start", 64'(core_start), 64'd0);
        checkOutput("rst_core_resume", 64'(core_resume), 64'd0);
        checkOutput("rst_msg_done", 64'(msg_done), 64'd0);
        checkBlockOutput("rst_block", block_data, '0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // "abc"
        msgq = '{8'h61, 8'h62, 8'h63};
        issued.delete();
        md_before = md_count;
        applyStimulus(1'b0);
        waitIdle();
        checkOutput("abc_blocks", 64'(issued.size()), 64'd1);
        checkOutput("abc_msg_done", 64'(md_count - md_before), 64'd1);
        if (issued.size() >= 1) begin
            checkOutput("abc_b2", 64'(issuedByte(0, 2)), 64'h63);
            checkOutput("abc_b3", 64'(issuedByte(0, 3)), 64'h80);
            checkOutput("abc_b56", 64'(issuedByte(0, 56)), 64'h18);
        end

        // Empty message.
        msgq.delete();
        issued.delete();
        applyStimulus(1'b0);
        waitIdle();
        checkOutput("empty_blocks", 64'(issued.size()), 64'd1);
        if (issued.size() >= 1) begin
            checkOutput("empty_b0", 64'(issuedByte(0, 0)), 64'h80);
            checkOutput("empty_b56", 64'(issuedByte(0, 56)), 64'h00);
        end

        // 56 bytes: marker at byte 56, length in a second block.
        msgq.delete();
        for (int i = 0; i < 56; i++) msgq.push_back(8'h61);
        issued.delete();
        applyStimulus(1'b0);
        waitIdle();
        checkOutput("m56_blocks", 64'(issued.size()), 64'd2);
        if (issued.size() >= 2) begin
            checkOutput("m56_b1_56", 64'(issuedByte(0, 56)), 64'h80);
            checkOutput("m56_b1_57", 64'(issuedByte(0, 57)), 64'h00);
            checkOutput("m56_b2_0", 64'(issuedByte(1, 0)), 64'h00);
            checkOutput("m56_b2_56", 64'(issuedByte(1, 56)), 64'hC0);
            checkOutput("m56_b2_57", 64'(issuedByte(1, 57)), 64'h01);
        end

        // 64 bytes: exact block boundary.
        msgq.delete();
        for (int i = 0; i < 64; i++) msgq.push_back(8'(i + 1));
        issued.delete();
        md_before = md_count;
        applyStimulus(1'b0);
        waitIdle();
        checkOutput("m64_blocks", 64'(issued.size()), 64'd2);
        checkOutput("m64_msg_done", 64'(md_count - md_before), 64'd1);
        if (issued.size() >= 2) begin
            checkOutput("m64_b1_63", 64'(issuedByte(0, 63)), 64'h40);
            checkOutput("m64_b2_0", 64'(issuedByte(1, 0)), 64'h80);
            checkOutput("m64_b2_56", 64'(issuedByte(1, 56)), 64'h00);
            checkOutput("m64_b2_57", 64'(issuedByte(1, 57)), 64'h02);
        end

        // 130 bytes with in_valid held high the whole time.
        msgq.delete();
        for (int i = 0; i < 130; i++) msgq.push_back(8'($urandom));
        issued.delete();
        applyStimulus(1'b0);
        waitIdle();
        checkOutput("m130_blocks", 64'(issued.size()), 64'd3);
        if (issued.size() >= 3) begin
            checkOutput("m130_b3_2", 64'(issuedByte(2, 2)), 64'h80);
            checkOutput("m130_b3_56", 64'(issuedByte(2, 56)), 64'h10);
            checkOutput("m130_b3_57", 64'(issuedByte(2, 57)), 64'h04);
        end

        // Reset while the core works on block 1 of a 70-byte message.
        msgq.delete();
        for (int i = 0; i < 70; i++) msgq.push_back(8'($urandom));
        buildExpected();
        for (int i = 0; i < 64; i++) sendBeat(msgq[i], 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (inflight) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("rst_test_issue_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_core_resume", 64'(core_resume), 64'd0);
        checkOutput("midrst_msg_done", 64'(msg_done), 64'd0);
        checkBlockOutput("midrst_block", block_data, '0);
        expq.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        msgq = '{8'h61, 8'h62, 8'h63};
        issued.delete();
        applyStimulus(1'b0);
        waitIdle();
        checkOutput("post_rst_abc_blocks", 64'(issued.size()), 64'd1);
        if (issued.size() >= 1) begin
            checkOutput("post_rst_abc_b0", 64'(issuedByte(0, 0)), 64'h61);
            checkOutput("post_rst_abc_b56", 64'(issuedByte(0, 56)), 64'h18);
        end

        // Random messages, sent back to back with random gaps.
        md_before = md_count;
        for (int m = 0; m < 25; m++) begin
            n = $urandom_range(0, 150);
            msgq.delete();
            for (int i = 0; i < n; i++) msgq.push_back(8'($urandom));
            applyStimulus(1'b1);
        end
        waitIdle();
        checkOutput("random_msg_done_count", 64'(md_count - md_before), 64'd25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
